// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the five-FIFO control block: sizes, threshold defaults
// and the state encoding used by the RTL and its bench.
package fifo_ctrl_pkg;

    localparam int NUM_FIFOS = 5;
    localparam int TH_W      = 3;
    localparam int ST_W      = 3;

    localparam logic [TH_W-1:0] AF_DEFAULT = 3'b110;
    localparam logic [TH_W-1:0] AE_DEFAULT = 3'b011;

    localparam logic [ST_W-1:0] ST_RESET  = 3'd0;
    localparam logic [ST_W-1:0] ST_INIT   = 3'd1;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd2;
    localparam logic [ST_W-1:0] ST_ACTIVE = 3'd3;
    localparam logic [ST_W-1:0] ST_ERROR  = 3'd4;

endpackage

// File: rtl/fifo_th_regs.sv
// Six almost-full/almost-empty threshold registers, loaded together on
// load_en and returned to the defaults on synchronous reset.
module fifo_th_regs
    import fifo_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_en,
    input  logic [TH_W-1:0] af_mf_in,
    input  logic [TH_W-1:0] ae_mf_in,
    input  logic [TH_W-1:0] af_vc_in,
    input  logic [TH_W-1:0] ae_vc_in,
    input  logic [TH_W-1:0] af_d_in,
    input  logic [TH_W-1:0] ae_d_in,
    output logic [TH_W-1:0] af_mf_out,
    output logic [TH_W-1:0] ae_mf_out,
    output logic [TH_W-1:0] af_vc_out,
    output logic [TH_W-1:0] ae_vc_out,
    output logic [TH_W-1:0] af_d_out,
    output logic [TH_W-1:0] ae_d_out
);

    localparam logic [6*TH_W-1:0] TH_DEFAULTS =
        {AE_DEFAULT, AF_DEFAULT, AE_DEFAULT, AF_DEFAULT, AE_DEFAULT, AF_DEFAULT};

    logic [6*TH_W-1:0] th_d;
    logic [6*TH_W-1:0] th_q;

    // Next threshold values: take the inputs only while loading
    always_comb begin
        th_d = th_q;
        if (load_en) begin
            th_d = {ae_d_in, af_d_in, ae_vc_in, af_vc_in, ae_mf_in, af_mf_in};
        end else begin
            th_d = th_q;
        end
    end

    // Threshold storage
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q <= TH_DEFAULTS;
        end else begin
            th_q <= th_d;
        end
    end

    assign {ae_d_out, af_d_out, ae_vc_out, af_vc_out, ae_mf_out, af_mf_out} = th_q;

endmodule

// File: rtl/fifo_ctrl_fsm.sv
// Control FSM for the five-FIFO datapath: threshold initialization,
// idle/active tracking from the empty flags and a sticky error vector.
module fifo_ctrl_fsm
    import fifo_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [NUM_FIFOS-1:0] fifo_errors,
    input  logic [NUM_FIFOS-1:0] fifo_empties,
    input  logic [TH_W-1:0]      af_mf_in,
    input  logic [TH_W-1:0]      ae_mf_in,
    input  logic [TH_W-1:0]      af_vc_in,
    input  logic [TH_W-1:0]      ae_vc_in,
    input  logic [TH_W-1:0]      af_d_in,
    input  logic [TH_W-1:0]      ae_d_in,
    output logic [TH_W-1:0]      af_mf_out,
    output logic [TH_W-1:0]      ae_mf_out,
    output logic [TH_W-1:0]      af_vc_out,
    output logic [TH_W-1:0]      ae_vc_out,
    output logic [TH_W-1:0]      af_d_out,
    output logic [TH_W-1:0]      ae_d_out,
    output logic [NUM_FIFOS-1:0] error_out,
    output logic                 active_out,
    output logic                 idle_out,
    output logic [ST_W-1:0]      state_out
);

    logic [ST_W-1:0]      state_d,  state_q;
    logic [NUM_FIFOS-1:0] error_d,  error_q;
    logic                 active_d, active_q;
    logic                 idle_d,   idle_q;
    logic                 init_q;
    logic                 init_rise_s;
    logic                 any_err_s;
    logic                 all_empty_s;

    assign init_rise_s = init & ~init_q;
    assign any_err_s   = |fifo_errors;
    assign all_empty_s = (fifo_empties == {NUM_FIFOS{1'b1}});

    // Next-state and error-vector logic; errors outrank re-init, re-init outranks empties
    always_comb begin
        state_d = state_q;
        error_d = {NUM_FIFOS{1'b0}};
        case (state_q)
            ST_RESET: begin
                if (init) state_d = ST_INIT;
                else      state_d = ST_RESET;
            end
            ST_INIT: begin
                if (any_err_s) begin
                    state_d = ST_ERROR;
                    error_d = fifo_errors;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE, ST_ACTIVE: begin
                if (any_err_s) begin
                    state_d = ST_ERROR;
                    error_d = fifo_errors;
                end else if (init_rise_s) begin
                    state_d = ST_INIT;
                end else if (all_empty_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
                error_d = error_q | fifo_errors;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
        idle_d   = (state_d == ST_IDLE);
        active_d = (state_d == ST_ACTIVE);
    end

    // State, status and init-edge registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RESET;
            error_q  <= {NUM_FIFOS{1'b0}};
            active_q <= 1'b0;
            idle_q   <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            error_q  <= error_d;
            active_q <= active_d;
            idle_q   <= idle_d;
            init_q   <= init;
        end
    end

    fifo_th_regs u_th_regs (
        .clk       (clk),
        .reset     (reset),
        .load_en   (state_q == ST_INIT),
        .af_mf_in  (af_mf_in),
        .ae_mf_in  (ae_mf_in),
        .af_vc_in  (af_vc_in),
        .ae_vc_in  (ae_vc_in),
        .af_d_in   (af_d_in),
        .ae_d_in   (ae_d_in),
        .af_mf_out (af_mf_out),
        .ae_mf_out (ae_mf_out),
        .af_vc_out (af_vc_out),
        .ae_vc_out (ae_vc_out),
        .af_d_out  (af_d_out),
        .ae_d_out  (ae_d_out)
    );

    assign state_out  = state_q;
    assign error_out  = error_q;
    assign active_out = active_q;
    assign idle_out   = idle_q;

endmodule
